vai_regfile: RTL

Parametrised successor of the VAI register slave. It is a register file of REG_DEPTH words of DATA_W bits, accessed through one VAI request stream (valid/accept/start/stop framing) and one VAI response stream. It adds auto-incrementing burst reads and writes, back-to-back response words with no bubble cycles, and a multi-bit status word. It sits behind the VAI interconnect as a generic configuration/status slave.

---
 rtl/vai_regfile.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vai_regfile.sv
// vai_regfile: REG_DEPTH x DATA_W register file behind a VAI request stream
// (Din*) and a VAI response stream (Dout*), with auto-increment bursts.
// Ports: Clk_i, Reset_n_i (async, active-low); request Din_i/DinValid_i/
// DinStart_i/DinStop_i/DinAccept_o; response Dout_o/DoutValid_o/
// DoutStart_o/DoutStop_o/DoutAccept_i.
module vai_regfile #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int REG_DEPTH = 8
) (
    input  logic              Clk_i,
    input  logic              Reset_n_i,
    input  logic [DATA_W-1:0] Din_i,
    input  logic              DinValid_i,
    input  logic              DinStart_i,
    input  logic              DinStop_i,
    output logic              DinAccept_o,
    output logic [DATA_W-1:0] Dout_o,
    output logic              DoutValid_o,
    output logic              DoutStart_o,
    output logic              DoutStop_o,
    input  logic              DoutAccept_i
);

    localparam int IW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = REG_DEPTH[ADDR_W:0];
    localparam logic [DATA_W:0] CNT_ONE = (DATA_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE, GET_HEADER, GET_COUNT, GET_DATA,
        DRAIN, SEND_HEADER, SEND_DATA, SEND_STATUS
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] regs [REG_DEPTH];
    logic [DATA_W-1:0] hdr;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] nptr;
    // count of data words still to send; holds up to 2**DATA_W
    logic [DATA_W:0]   cnt;
    logic              cmd_err;
    logic              frame_err;
    logic              addr_err;

    logic              din_xfer;
    logic              dout_xfer;
    logic [3:0]        din_cmd;
    logic [ADDR_W-1:0] din_addr;
    logic              ptr_ok;
    logic              nptr_ok;
    logic [DATA_W-1:0] rd_ptr;
    logic [DATA_W-1:0] rd_nptr;
    logic [DATA_W-1:0] status_w;
    logic              hdr_read;

    assign din_xfer  = DinValid_i && DinAccept_o;
    assign dout_xfer = DoutValid_o && DoutAccept_i;
    assign din_cmd   = Din_i[3:0];
    assign din_addr  = Din_i[ADDR_W+3:4];
    assign nptr      = ptr + 1'b1;
    assign ptr_ok    = {1'b0, ptr} < DEPTH_C;
    assign nptr_ok   = {1'b0, nptr} < DEPTH_C;
    assign rd_ptr    = ptr_ok ? regs[ptr[IW-1:0]] : '0;
    assign rd_nptr   = nptr_ok ? regs[nptr[IW-1:0]] : '0;
    assign status_w  = {{(DATA_W-3){1'b0}}, frame_err, cmd_err, addr_err};
    assign hdr_read  = (hdr[3:0] == 4'd0) && !frame_err && !cmd_err;

    // Response word and flags are registered and only move on a response
    // transfer, so they hold stable under backpressure.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state       <= IDLE;
            hdr         <= '0;
            ptr         <= '0;
            cnt         <= '0;
            cmd_err     <= 1'b0;
            frame_err   <= 1'b0;
            addr_err    <= 1'b0;
            DinAccept_o <= 1'b0;
            Dout_o      <= '0;
            DoutValid_o <= 1'b0;
            DoutStart_o <= 1'b0;
            DoutStop_o  <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE: state <= GET_HEADER;

                GET_HEADER: begin
                    DinAccept_o <= 1'b1;
                    // words without start are not headers; drop them
                    if (din_xfer && DinStart_i) begin
                        hdr <= Din_i;
                        ptr <= din_addr;
                        cnt <= CNT_ONE;
                        if (din_cmd > 4'd1) cmd_err <= 1'b1;
                        if (DinStop_i) begin
                            state       <= SEND_HEADER;
                            DinAccept_o <= 1'b0;
                            DoutValid_o <= 1'b1;
                            DoutStart_o <= 1'b1;
                            Dout_o      <= Din_i;
                        end else if (din_cmd == 4'd0) begin
                            state <= GET_COUNT;
                        end else if (din_cmd == 4'd1) begin
                            state <= GET_DATA;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                GET_COUNT: begin
                    if (din_xfer) begin
                        cnt <= {1'b0, Din_i} + 1'b1;
                        if (!DinStop_i || DinStart_i) frame_err <= 1'b1;
                        if (DinStop_i) begin
                            state       <= SEND_HEADER;
                            DinAccept_o <= 1'b0;
                            DoutValid_o <= 1'b1;
                            DoutStart_o <= 1'b1;
                            Dout_o      <= hdr;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end

                GET_DATA: begin
                    if (din_xfer) begin
                        if (DinStart_i) begin
                            frame_err <= 1'b1;
                        end else begin
                            if (ptr_ok) regs[ptr[IW-1:0]] <= Din_i;
                            else addr_err <= 1'b1;
                            ptr <= nptr;
                        end
                        if (DinStop_i) begin
                            state       <= SEND_HEADER;
                            DinAccept_o <= 1'b0;
                            DoutValid_o <= 1'b1;
                            DoutStart_o <= 1'b1;
                            Dout_o      <= hdr;
                        end else if (DinStart_i) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (din_xfer && DinStop_i) begin
                        state       <= SEND_HEADER;
                        DinAccept_o <= 1'b0;
                        DoutValid_o <= 1'b1;
                        DoutStart_o <= 1'b1;
                        Dout_o      <= hdr;
                    end
                end

                SEND_HEADER: begin
                    if (dout_xfer) begin
                        DoutStart_o <= 1'b0;
                        if (hdr_read) begin
                            state  <= SEND_DATA;
                            Dout_o <= rd_ptr;
                            if (!ptr_ok) addr_err <= 1'b1;
                        end else begin
                            state      <= SEND_STATUS;
                            DoutStop_o <= 1'b1;
                            Dout_o     <= status_w;
                        end
                    end
                end

                SEND_DATA: begin
                    if (dout_xfer) begin
                        ptr <= nptr;
                        cnt <= cnt - 1'b1;
                        // addr_err already covers the word just sent
                        if (cnt == CNT_ONE) begin
                            state      <= SEND_STATUS;
                            DoutStop_o <= 1'b1;
                            Dout_o     <= status_w;
                        end else begin
                            Dout_o <= rd_nptr;
                            if (!nptr_ok) addr_err <= 1'b1;
                        end
                    end
                end

                SEND_STATUS: begin
                    if (dout_xfer) begin
                        state       <= GET_HEADER;
                        cmd_err     <= 1'b0;
                        frame_err   <= 1'b0;
                        addr_err    <= 1'b0;
                        DoutValid_o <= 1'b0;
                        DoutStop_o  <= 1'b0;
                        Dout_o      <= '0;
                        DinAccept_o <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
